// File: rtl/mure_pkg.sv
// Shared widths and the trace block record used by the
// multiple-retirement trace path.
package mure_pkg;

    localparam int XLEN        = 32;
    localparam int IRETIRE_LEN = 32;
    localparam int ITYPE_LEN   = 3;
    localparam int CAUSE_LEN   = 5;
    localparam int PRIV_LEN    = 2;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
        logic [XLEN-1:0]        iaddr;
    } te_blk_t;

endpackage

// File: rtl/te_block_scheduler_if.sv
// Head-of-queue valid/ready channel from the block scheduler
// toward the single-port trace encoder.
interface te_block_scheduler_if;
    import mure_pkg::*;

    logic                   valid;
    logic                   ready;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        iaddr;

    modport master (
        output valid, iretire, ilastsize, itype,
        output cause, tval, priv, iaddr,
        input  ready
    );

    modport slave (
        input  valid, iretire, ilastsize, itype,
        input  cause, tval, priv, iaddr,
        output ready
    );

endinterface

// File: rtl/te_block_scheduler.sv
// Buffers up to N parallel trace blocks per cycle and streams them out
// one per cycle, oldest lane first. Optional core stall: TE_SCHED_STALL_EN.
module te_block_scheduler
    import mure_pkg::*;
#(
    parameter int N          = 2,
    parameter int DEPTH      = 8,
    parameter int DROP_CNT_W = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [N-1:0]                valid_i,
    input  logic [N-1:0][IRETIRE_LEN-1:0] iretire_i,
    input  logic [N-1:0]                ilastsize_i,
    input  logic [N-1:0][ITYPE_LEN-1:0] itype_i,
    input  logic [N-1:0][XLEN-1:0]      iaddr_i,
    input  logic [CAUSE_LEN-1:0]        cause_i,
    input  logic [XLEN-1:0]             tval_i,
    input  logic [PRIV_LEN-1:0]         priv_i,
    te_block_scheduler_if.master        out,
    output logic                        empty_o,
    output logic                        full_o,
    output logic                        overflow_o,
    output logic [DROP_CNT_W-1:0]       drop_cnt_o,
    output logic                        stall_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_BP     = 2'd2;

    te_blk_t               mem [DEPTH];
    te_blk_t               rec [N];
    te_blk_t               head;
    logic [AW-1:0]         rptr_q;
    logic [AW-1:0]         wptr_q;
    logic [N-1:0][AW-1:0]  slot;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [CW-1:0]         k;
    logic [CW-1:0]         room;
    logic                  fits;
    logic                  acc;
    logic                  drop;
    logic                  head_vld;
    logic                  pop;
    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  ovf_q;
    logic [DROP_CNT_W-1:0] drop_q;

    // Compact valid lanes into consecutive slots and build their records.
    always_comb begin
        k = '0;
        for (int i = 0; i < N; i++) begin
            slot[i]          = wptr_q + k[AW-1:0];
            k                = k + CW'(valid_i[i]);
            rec[i]           = '0;
            rec[i].iretire   = iretire_i[i];
            rec[i].ilastsize = ilastsize_i[i];
            rec[i].itype     = itype_i[i];
            rec[i].priv      = priv_i;
            rec[i].iaddr     = iaddr_i[i];
        end
        rec[0].cause = cause_i;
        rec[0].tval  = tval_i;
    end

    // Whole-group admission against start-of-cycle occupancy.
    always_comb begin
        head_vld = (cnt_q != '0);
        pop      = head_vld && out.ready;
        room     = CW'(DEPTH) - cnt_q;
        fits     = (k <= room);
        acc      = !flush_i && (k != '0) && fits;
        drop     = !flush_i && (k != '0) && !fits;
        if (flush_i)
            cnt_d = '0;
        else
            cnt_d = cnt_q + (acc ? k : '0) - CW'(pop);
    end

    // Output-side FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY:  if (cnt_d != '0) state_d = S_STREAM;
            S_STREAM: if (head_vld && !out.ready) state_d = S_BP;
            S_BP:     if (out.ready) state_d = S_STREAM;
            default:  state_d = S_EMPTY;
        endcase
        if (flush_i || cnt_d == '0)
            state_d = S_EMPTY;
    end

    // Queue storage: accepted lanes land in their compacted slots.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < DEPTH; j++)
                mem[j] <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (acc && valid_i[i])
                    mem[slot[i]] <= rec[i];
        end
    end

    // Pointers, occupancy and FSM state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush_i) begin
                rptr_q <= '0;
                wptr_q <= '0;
            end else begin
                if (pop)
                    rptr_q <= rptr_q + 1'b1;
                if (acc)
                    wptr_q <= wptr_q + k[AW-1:0];
            end
        end
    end

    // Sticky overflow flag and saturating drop counter survive flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != '1)
                drop_q <= drop_q + 1'b1;
        end
    end

`ifdef TE_SCHED_STALL_EN
    logic stall_q;

    // Stall tracks the registered count reaching the last-group margin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            stall_q <= 1'b0;
        else
            stall_q <= (cnt_d >= CW'(DEPTH - N));
    end

    assign stall_o = stall_q;
`else
    assign stall_o = 1'b0;
`endif

    assign head = head_vld ? mem[rptr_q] : '0;

    assign out.valid     = head_vld;
    assign out.iretire   = head.iretire;
    assign out.ilastsize = head.ilastsize;
    assign out.itype     = head.itype;
    assign out.cause     = head.cause;
    assign out.tval      = head.tval;
    assign out.priv      = head.priv;
    assign out.iaddr     = head.iaddr;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CW'(DEPTH));
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_te_block_scheduler.sv
// Randomized and directed checks of te_block_scheduler against a
// queue-based reference model.
module tb_te_block_scheduler;
    import mure_pkg::*;

    localparam int N          = 2;
    localparam int DEPTH      = 8;
    localparam int DROP_CNT_W = 8;
    localparam int DROP_MAX   = (1 << DROP_CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic flush_i;
    logic [N-1:0] valid_i;
    logic [N-1:0][IRETIRE_LEN-1:0] iretire_i;
    logic [N-1:0] ilastsize_i;
    logic [N-1:0][ITYPE_LEN-1:0] itype_i;
    logic [N-1:0][XLEN-1:0] iaddr_i;
    logic [CAUSE_LEN-1:0] cause_i;
    logic [XLEN-1:0] tval_i;
    logic [PRIV_LEN-1:0] priv_i;
    logic empty_o, full_o, overflow_o, stall_o;
    logic [DROP_CNT_W-1:0] drop_cnt_o;

    te_block_scheduler_if u_if ();

    te_block_scheduler #(
        .N(N), .DEPTH(DEPTH), .DROP_CNT_W(DROP_CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .valid_i(valid_i), .iretire_i(iretire_i),
        .ilastsize_i(ilastsize_i), .itype_i(itype_i),
        .iaddr_i(iaddr_i), .cause_i(cause_i), .tval_i(tval_i),
        .priv_i(priv_i), .out(u_if.master),
        .empty_o(empty_o), .full_o(full_o),
        .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
        .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;

    te_blk_t q [$];
    bit m_ovf = 0;
    int m_drops = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rnd_data();
        for (int i = 0; i < N; i++) begin
            iretire_i[i]   = $urandom;
            ilastsize_i[i] = 1'($urandom);
            itype_i[i]     = ITYPE_LEN'($urandom);
            iaddr_i[i]     = $urandom;
        end
        cause_i = CAUSE_LEN'($urandom);
        tval_i  = $urandom;
        priv_i  = PRIV_LEN'($urandom);
    endtask

    task automatic compare_all();
        bit exp_stall;
        exp_stall = 1'b0;
`ifdef TE_SCHED_STALL_EN
        exp_stall = (q.size() >= DEPTH - N);
`endif
        check("valid", 64'(u_if.valid), 64'(q.size() != 0));
        check("empty", 64'(empty_o), 64'(q.size() == 0));
        check("full", 64'(full_o), 64'(q.size() == DEPTH));
        check("ovf", 64'(overflow_o), 64'(m_ovf));
        check("drops", 64'(drop_cnt_o), 64'(m_drops));
        check("stall", 64'(stall_o), 64'(exp_stall));
        if (q.size() != 0) begin
            check("iretire", 64'(u_if.iretire), 64'(q[0].iretire));
            check("ilast", 64'(u_if.ilastsize), 64'(q[0].ilastsize));
            check("itype", 64'(u_if.itype), 64'(q[0].itype));
            check("cause", 64'(u_if.cause), 64'(q[0].cause));
            check("tval", 64'(u_if.tval), 64'(q[0].tval));
            check("priv", 64'(u_if.priv), 64'(q[0].priv));
            check("iaddr", 64'(u_if.iaddr), 64'(q[0].iaddr));
        end
    endtask

    // Model one clock edge with the inputs currently applied, then compare.
    task automatic cycle();
        int k;
        bit pop;
        bit fits;
        te_blk_t b;
        k = $countones(valid_i);
        pop = (q.size() != 0) && u_if.ready;
        if (flush_i) begin
            q.delete();
        end else begin
            fits = (k <= DEPTH - q.size());
            if (k != 0 && !fits) begin
                m_ovf = 1'b1;
                if (m_drops < DROP_MAX) m_drops++;
            end
            if (pop) void'(q.pop_front());
            if (k != 0 && fits) begin
                for (int i = 0; i < N; i++) begin
                    if (valid_i[i]) begin
                        b.iretire   = iretire_i[i];
                        b.ilastsize = ilastsize_i[i];
                        b.itype     = itype_i[i];
                        b.priv      = priv_i;
                        b.iaddr     = iaddr_i[i];
                        b.cause     = (i == 0) ? cause_i : '0;
                        b.tval      = (i == 0) ? tval_i : '0;
                        q.push_back(b);
                    end
                end
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic go(logic [N-1:0] v, logic r, logic f);
        rnd_data();
        valid_i   = v;
        u_if.ready = r;
        flush_i   = f;
        cycle();
    endtask

    logic [XLEN-1:0] held;

    initial begin
        rst_ni = 1'b0;
        flush_i = 1'b0;
        valid_i = '0;
        u_if.ready = 1'b0;
        rnd_data();
        repeat (3) @(negedge clk_i);
        check("rst_valid", 64'(u_if.valid), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_iaddr", 64'(u_if.iaddr), 64'd0);
        check("rst_cause", 64'(u_if.cause), 64'd0);
        rst_ni = 1'b1;

        // Two-lane push, streamed out in lane order
        rnd_data();
        valid_i = 2'b11;
        u_if.ready = 1'b1;
        cause_i = 5'h1b;
        tval_i = 32'hdeadbeef;
        cycle();
        check("first_cause", 64'(u_if.cause), 64'h1b);
        go(2'b00, 1'b1, 1'b0);
        check("second_cause", 64'(u_if.cause), 64'h0);
        check("second_tval", 64'(u_if.tval), 64'h0);
        go(2'b00, 1'b1, 1'b0);
        check("drain_empty", 64'(empty_o), 64'd1);

        // Sparse lane
        rnd_data();
        valid_i = 2'b10;
        u_if.ready = 1'b1;
        iaddr_i[1] = 32'h80000010;
        cycle();
        check("sparse_iaddr", 64'(u_if.iaddr), 64'h80000010);
        go(2'b00, 1'b1, 1'b0);

        // Backpressure: fill, hold head stable, drop the fifth group
        go(2'b11, 1'b0, 1'b0);
        held = u_if.iaddr;
        for (int g = 0; g < 4; g++) begin
            go(2'b11, 1'b0, 1'b0);
            check("bp_hold", 64'(u_if.iaddr), 64'(held));
        end
        check("bp_full", 64'(full_o), 64'd1);
        check("bp_drop", 64'(drop_cnt_o), 64'd1);
        check("bp_ovf", 64'(overflow_o), 64'd1);
        for (int i = 0; i < DEPTH; i++) go(2'b00, 1'b1, 1'b0);
        check("bp_empty", 64'(empty_o), 64'd1);

        // Full queue with same-cycle pop and push
        for (int g = 0; g < 4; g++) go(2'b11, 1'b0, 1'b0);
        go(2'b01, 1'b1, 1'b0);
        check("fullpop_full", 64'(full_o), 64'd0);
        check("fullpop_drop", 64'(drop_cnt_o), 64'd2);

        // Flush at count 5 with a same-cycle push
        go(2'b00, 1'b0, 1'b1);
        go(2'b11, 1'b0, 1'b0);
        go(2'b11, 1'b0, 1'b0);
        go(2'b01, 1'b0, 1'b0);
        go(2'b11, 1'b0, 1'b1);
        check("flush_valid", 64'(u_if.valid), 64'd0);
        check("flush_drop", 64'(drop_cnt_o), 64'd2);

        // Randomized traffic with rare flushes and one async reset
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                rst_ni = 1'b0;
                #1;
                q.delete();
                m_ovf = 1'b0;
                m_drops = 0;
                check("arst_valid", 64'(u_if.valid), 64'd0);
                check("arst_empty", 64'(empty_o), 64'd1);
                check("arst_drops", 64'(drop_cnt_o), 64'd0);
                @(negedge clk_i);
                rst_ni = 1'b1;
            end
            go(N'($urandom), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 63) == 0));
        end

        // Drop counter saturation
        go(2'b00, 1'b0, 1'b1);
        for (int g = 0; g < 4; g++) go(2'b11, 1'b0, 1'b0);
        for (int g = 0; g < 300; g++) go(N'($urandom_range(1, 3)), 1'b0, 1'b0);
        check("sat_drop", 64'(drop_cnt_o), 64'(DROP_MAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
